npc_predictor: RTL and testbench

NPC_PREDICTOR -- requirements
Module: npc_predictor

---
 rtl/npc_predictor.sv | 247 ++++++++++++++++++++++++
 tb/tb_npc_predictor.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/npc_predictor.sv
// npc_predictor: next-fetch-PC predictor combining a direct-mapped branch
// target buffer (BTB) with a circular return-address stack (RAS).
//
// Ports
//   clk          : single clock, all state updates on its rising edge
//   resetn       : asynchronous active-low reset, clears all learned state
//   f_pc         : fetch PC being looked up
//   f_pred_pc    : predicted next fetch PC (combinational from stored state)
//   f_pred_taken : 1 when f_pred_pc was selected as something other than f_pc+4
//   e_valid      : a resolved control-transfer instruction from Execute
//   e_pc         : PC of the resolved instruction
//   e_kind       : 0 cond branch, 1 jump, 2 call, 3 return
//   e_taken      : actual outcome (always 1 for kinds 1..3)
//   e_target     : actual target address
//   e_pred_pc    : next PC that was predicted for e_pc at fetch
//   e_mispredict : e_valid and actual next PC differs from e_pred_pc
module npc_predictor #(
  parameter int ENTRIES   = 16,
  parameter int RAS_DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] f_pc,
  output logic [31:0] f_pred_pc,
  output logic        f_pred_taken,
  input  logic        e_valid,
  input  logic [31:0] e_pc,
  input  logic [1:0]  e_kind,
  input  logic        e_taken,
  input  logic [31:0] e_target,
  input  logic [31:0] e_pred_pc,
  output logic        e_mispredict
);

  localparam int IDX = $clog2(ENTRIES);
  localparam int TW  = 30 - IDX;
  localparam int PW  = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CW  = $clog2(RAS_DEPTH + 1);
  localparam logic [PW-1:0] PTR_MAX = PW'(RAS_DEPTH - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(RAS_DEPTH);

  // BTB state
  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TW-1:0]      tag_q    [ENTRIES];
  logic [TW-1:0]      tag_d    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [31:0]        target_d [ENTRIES];
  logic [1:0]         kind_q   [ENTRIES];
  logic [1:0]         kind_d   [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];
  logic [1:0]         ctr_d    [ENTRIES];

  // RAS state: ras_ptr_q is the slot the next push writes; top is one below it.
  logic [31:0]   ras_q [RAS_DEPTH];
  logic [31:0]   ras_d [RAS_DEPTH];
  logic [PW-1:0] ras_ptr_q, ras_ptr_d;
  logic [CW-1:0] ras_cnt_q, ras_cnt_d;

  logic [PW-1:0] ptr_inc;
  logic [PW-1:0] ptr_dec;
  logic [31:0]   ras_top;

  logic [IDX-1:0] f_idx;
  logic [TW-1:0]  f_tag;
  logic           f_hit;
  logic [31:0]    f_seq;

  logic [IDX-1:0] e_idx;
  logic [TW-1:0]  e_tag;
  logic           e_hit;
  logic [31:0]    e_actual;

  assign f_idx = f_pc[IDX+1:2];
  assign f_tag = f_pc[31:IDX+2];
  assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign f_seq = f_pc + 32'd4;

  assign e_idx    = e_pc[IDX+1:2];
  assign e_tag    = e_pc[31:IDX+2];
  assign e_hit    = valid_q[e_idx] && (tag_q[e_idx] == e_tag);
  assign e_actual = e_taken ? e_target : (e_pc + 32'd8);  // delay slot skipped

  assign e_mispredict = e_valid && (e_actual != e_pred_pc);

  // Circular pointer neighbours; explicit wrap so non-power-of-two depths work.
  always_comb begin
    if (ras_ptr_q == PTR_MAX) begin
      ptr_inc = '0;
    end else begin
      ptr_inc = ras_ptr_q + PW'(1);
    end
    if (ras_ptr_q == '0) begin
      ptr_dec = PTR_MAX;
    end else begin
      ptr_dec = ras_ptr_q - PW'(1);
    end
  end

  assign ras_top = ras_q[ptr_dec];

  // Fetch-side prediction; f_pred_taken follows the selection, not a compare.
  always_comb begin
    f_pred_pc    = f_seq;
    f_pred_taken = 1'b0;
    if (f_hit) begin
      case (kind_q[f_idx])
        2'd0: begin
          if (ctr_q[f_idx][1]) begin
            f_pred_pc    = target_q[f_idx];
            f_pred_taken = 1'b1;
          end else begin
            f_pred_pc    = f_seq;
            f_pred_taken = 1'b0;
          end
        end
        2'd1, 2'd2: begin
          f_pred_pc    = target_q[f_idx];
          f_pred_taken = 1'b1;
        end
        2'd3: begin
          if (ras_cnt_q != '0) begin
            f_pred_pc = ras_top;
          end else begin
            f_pred_pc = target_q[f_idx];
          end
          f_pred_taken = 1'b1;
        end
        default: begin
          f_pred_pc    = f_seq;
          f_pred_taken = 1'b0;
        end
      endcase
    end else begin
      f_pred_pc    = f_seq;
      f_pred_taken = 1'b0;
    end
  end

  // BTB next-state: train on hit, allocate on miss unless not-taken branch.
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    kind_d   = kind_q;
    ctr_d    = ctr_q;
    if (e_valid) begin
      if (e_hit) begin
        kind_d[e_idx] = e_kind;
        if (e_taken) begin
          target_d[e_idx] = e_target;
        end else begin
          target_d[e_idx] = target_q[e_idx];
        end
        if (e_kind == 2'd0) begin
          if (e_taken) begin
            if (ctr_q[e_idx] != 2'b11) begin
              ctr_d[e_idx] = ctr_q[e_idx] + 2'd1;
            end else begin
              ctr_d[e_idx] = 2'b11;
            end
          end else begin
            if (ctr_q[e_idx] != 2'b00) begin
              ctr_d[e_idx] = ctr_q[e_idx] - 2'd1;
            end else begin
              ctr_d[e_idx] = 2'b00;
            end
          end
        end else begin
          ctr_d[e_idx] = ctr_q[e_idx];
        end
      end else if (e_taken || (e_kind != 2'd0)) begin
        valid_d[e_idx]  = 1'b1;
        tag_d[e_idx]    = e_tag;
        target_d[e_idx] = e_target;
        kind_d[e_idx]   = e_kind;
        ctr_d[e_idx]    = e_taken ? 2'b10 : 2'b01;
      end else begin
        valid_d = valid_q;
      end
    end else begin
      valid_d = valid_q;
    end
  end

  // RAS next-state: calls push (overwriting oldest when full), returns pop.
  always_comb begin
    ras_d     = ras_q;
    ras_ptr_d = ras_ptr_q;
    ras_cnt_d = ras_cnt_q;
    if (e_valid) begin
      case (e_kind)
        2'd2: begin
          ras_d[ras_ptr_q] = e_pc + 32'd8;
          ras_ptr_d        = ptr_inc;
          if (ras_cnt_q != CNT_MAX) begin
            ras_cnt_d = ras_cnt_q + CW'(1);
          end else begin
            ras_cnt_d = CNT_MAX;
          end
        end
        2'd3: begin
          if (ras_cnt_q != '0) begin
            ras_ptr_d = ptr_dec;
            ras_cnt_d = ras_cnt_q - CW'(1);
          end else begin
            ras_ptr_d = ras_ptr_q;
            ras_cnt_d = ras_cnt_q;
          end
        end
        default: begin
          ras_ptr_d = ras_ptr_q;
          ras_cnt_d = ras_cnt_q;
        end
      endcase
    end else begin
      ras_ptr_d = ras_ptr_q;
    end
  end

  // State registers with asynchronous clear of all learned state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q   <= '0;
      ras_ptr_q <= '0;
      ras_cnt_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= 32'd0;
        kind_q[i]   <= 2'd0;
        ctr_q[i]    <= 2'b01;
      end
      for (int j = 0; j < RAS_DEPTH; j++) begin
        ras_q[j] <= 32'd0;
      end
    end else begin
      valid_q   <= valid_d;
      tag_q     <= tag_d;
      target_q  <= target_d;
      kind_q    <= kind_d;
      ctr_q     <= ctr_d;
      ras_q     <= ras_d;
      ras_ptr_q <= ras_ptr_d;
      ras_cnt_q <= ras_cnt_d;
    end
  end

endmodule

// File: tb/tb_npc_predictor.sv
// Directed testbench for npc_predictor (ENTRIES=16, RAS_DEPTH=4).
module tb_npc_predictor;

  logic        clk;
  logic        resetn;
  logic [31:0] f_pc;
  logic [31:0] f_pred_pc;
  logic        f_pred_taken;
  logic        e_valid;
  logic [31:0] e_pc;
  logic [1:0]  e_kind;
  logic        e_taken;
  logic [31:0] e_target;
  logic [31:0] e_pred_pc;
  logic        e_mispredict;

  int n_checks = 0;
  int n_fail   = 0;

  npc_predictor #(.ENTRIES(16), .RAS_DEPTH(4)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .f_pc         (f_pc),
    .f_pred_pc    (f_pred_pc),
    .f_pred_taken (f_pred_taken),
    .e_valid      (e_valid),
    .e_pc         (e_pc),
    .e_kind       (e_kind),
    .e_taken      (e_taken),
    .e_target     (e_target),
    .e_pred_pc    (e_pred_pc),
    .e_mispredict (e_mispredict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic look(input string tag, input logic [31:0] pc,
                      input logic [31:0] exp_pc, input logic exp_tk);
    f_pc = pc;
    #1;
    check({tag, "_pc"}, f_pred_pc, exp_pc);
    check({tag, "_tk"}, {31'd0, f_pred_taken}, {31'd0, exp_tk});
  endtask

  task automatic upd(input logic [31:0] pc, input logic [1:0] kind,
                     input logic tk, input logic [31:0] tgt);
    e_valid   = 1'b1;
    e_pc      = pc;
    e_kind    = kind;
    e_taken   = tk;
    e_target  = tgt;
    e_pred_pc = 32'd0;
    @(posedge clk);
    #1;
    e_valid = 1'b0;
  endtask

  logic [31:0] pop_exp [5];

  initial begin
    pop_exp[0] = 32'h58; pop_exp[1] = 32'h48; pop_exp[2] = 32'h38;
    pop_exp[3] = 32'h28; pop_exp[4] = 32'h0;

    resetn = 1'b0; e_valid = 1'b0; e_pc = 32'd0; e_kind = 2'd0;
    e_taken = 1'b0; e_target = 32'd0; e_pred_pc = 32'd0; f_pc = 32'd0;

    // Cold miss under reset, mispredict stays combinational during reset
    look("cold", 32'hBFC00000, 32'hBFC00004, 1'b0);
    check("mp_idle_rst", {31'd0, e_mispredict}, 32'd0);
    e_valid = 1'b1; e_pc = 32'h100; e_kind = 2'd0; e_taken = 1'b0; e_pred_pc = 32'h200;
    #1;
    check("mp_in_rst", {31'd0, e_mispredict}, 32'd1);
    e_valid = 1'b0;
    #10;
    resetn = 1'b1;
    @(posedge clk);
    #1;
    look("cold2", 32'hBFC00000, 32'hBFC00004, 1'b0);

    // Taken training; same-cycle lookup still sees pre-update miss
    e_valid = 1'b1; e_pc = 32'h100; e_kind = 2'd0; e_taken = 1'b1; e_target = 32'h200;
    look("same_cycle", 32'h100, 32'h104, 1'b0);
    @(posedge clk);
    #1;
    e_valid = 1'b0;
    look("trained", 32'h100, 32'h200, 1'b1);

    // 10 -> 01 -> 00
    upd(32'h100, 2'd0, 1'b0, 32'h200);
    upd(32'h100, 2'd0, 1'b0, 32'h200);
    look("nt2", 32'h100, 32'h104, 1'b0);
    // 00 -> 01 -> 10 -> 11 -> 11, then not-taken gives 10 (still taken)
    upd(32'h100, 2'd0, 1'b1, 32'h200);
    upd(32'h100, 2'd0, 1'b1, 32'h200);
    upd(32'h100, 2'd0, 1'b1, 32'h200);
    look("t3", 32'h100, 32'h200, 1'b1);
    upd(32'h100, 2'd0, 1'b1, 32'h200);
    upd(32'h100, 2'd0, 1'b0, 32'h200);
    look("sat_hold", 32'h100, 32'h200, 1'b1);
    upd(32'h100, 2'd0, 1'b0, 32'h200);
    look("sat_down", 32'h100, 32'h104, 1'b0);

    // Mispredict flag (combinational, no clock edge while e_valid=1)
    e_valid = 1'b1; e_pc = 32'h100; e_kind = 2'd0; e_taken = 1'b0; e_pred_pc = 32'h200;
    #1;
    check("mp_nt_bad", {31'd0, e_mispredict}, 32'd1);
    e_pred_pc = 32'h108;
    #1;
    check("mp_nt_ok", {31'd0, e_mispredict}, 32'd0);
    e_taken = 1'b1; e_target = 32'h300; e_pred_pc = 32'h300;
    #1;
    check("mp_t_ok", {31'd0, e_mispredict}, 32'd0);
    e_pred_pc = 32'h108;
    #1;
    check("mp_t_bad", {31'd0, e_mispredict}, 32'd1);
    e_valid = 1'b0;
    #1;
    check("mp_invalid", {31'd0, e_mispredict}, 32'd0);

    // Call/return: two calls push 0x408 twice; return entry allocation pops one
    upd(32'h400, 2'd2, 1'b1, 32'h1000);
    upd(32'h400, 2'd2, 1'b1, 32'h1000);
    look("call", 32'h400, 32'h1000, 1'b1);
    upd(32'h800, 2'd3, 1'b1, 32'h0);
    look("ret_ras", 32'h800, 32'h408, 1'b1);
    upd(32'h800, 2'd3, 1'b1, 32'h0);
    look("ret_empty", 32'h800, 32'h0, 1'b1);
    upd(32'h800, 2'd3, 1'b1, 32'h0);
    look("ret_underflow", 32'h800, 32'h0, 1'b1);

    // RAS overflow
    upd(32'h904, 2'd3, 1'b1, 32'h0);
    for (int i = 1; i <= 5; i++) begin
      upd(32'h10 * i, 2'd2, 1'b1, 32'h3000);
    end
    for (int i = 0; i < 5; i++) begin
      look($sformatf("pop%0d", i), 32'h904, pop_exp[i], 1'b1);
      upd(32'h904, 2'd3, 1'b1, 32'h0);
    end

    // Aliasing at index 0, and no allocation on not-taken miss
    upd(32'h100, 2'd0, 1'b1, 32'h200);
    look("alias_a", 32'h100, 32'h200, 1'b1);
    upd(32'h140, 2'd0, 1'b1, 32'h500);
    look("alias_b", 32'h140, 32'h500, 1'b1);
    look("alias_evict", 32'h100, 32'h104, 1'b0);
    upd(32'h100, 2'd0, 1'b0, 32'h200);
    look("nt_miss_keep", 32'h140, 32'h500, 1'b1);
    look("nt_miss_noalloc", 32'h100, 32'h104, 1'b0);

    // e_valid=0 leaves state untouched
    e_valid = 1'b0; e_pc = 32'h140; e_kind = 2'd0; e_taken = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    look("no_valid", 32'h140, 32'h500, 1'b1);

    // Asynchronous reset mid-cycle
    @(negedge clk);
    resetn = 1'b0;
    look("rst_b", 32'h140, 32'h144, 1'b0);
    look("rst_ret", 32'h904, 32'h908, 1'b0);
    #2;
    resetn = 1'b1;
    @(posedge clk);
    #1;
    look("post_rst", 32'h140, 32'h144, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
